iiitb_r2_4bit_bm: RTL and testbench

//  - Sequential radix-2 Booth multiplier for two's-complement signed operands.
//  - Multiplicand M and multiplier Q are captured on load. One Booth step runs per clock.
//  - Signed product P is valid WIDTH cycles after load.
//  - Small arithmetic leaf block; any datapath needing a low-area signed multiply can use it.

---
 rtl/iiitb_r2_4bit_bm.sv | 89 ++++++++
 tb/tb_iiitb_r2_4bit_bm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iiitb_r2_4bit_bm.sv
// iiitb_r2_4bit_bm: sequential radix-2 Booth multiplier, signed operands.
// One Booth step per clock; the product is final WIDTH edges after the load edge.
// Optional feature macro: BM_DONE_EN adds a 1-bit 'done' output that flags a finished product.
module iiitb_r2_4bit_bm #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
`ifdef BM_DONE_EN
    output logic               done,
`endif
    output logic [2*WIDTH-1:0] P
);

    localparam int CW = $clog2(WIDTH + 1);

    // Datapath state; these names are probed from outside, so they keep their plain names.
    logic [WIDTH-1:0] M_temp;
    logic [WIDTH-1:0] Q_temp;
    logic             Q_minus_one;
    logic [WIDTH:0]   A;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   w_mext;
    logic [WIDTH:0]   w_acc;
    logic [WIDTH:0]   w_a_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_qm1_nxt;

    // One Booth step: add/subtract the sign-extended multiplicand, then shift the
    // {A, Q_temp, Q_minus_one} chain right arithmetically by one.
    always_comb begin
        w_mext = {M_temp[WIDTH-1], M_temp};
        w_acc  = A;
        case ({Q_temp[0], Q_minus_one})
            2'b01:   w_acc = A + w_mext;
            2'b10:   w_acc = A - w_mext;
            default: w_acc = A;
        endcase
        w_a_nxt   = {w_acc[WIDTH], w_acc[WIDTH:1]};
        w_q_nxt   = {w_acc[0], Q_temp[WIDTH-1:1]};
        w_qm1_nxt = Q_temp[0];
    end

    // Reset clears everything, load (re)starts a multiply, otherwise step until count hits 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            M_temp      <= '0;
            Q_temp      <= '0;
            Q_minus_one <= 1'b0;
            A           <= '0;
            count       <= '0;
        end else if (load) begin
            M_temp      <= M;
            Q_temp      <= Q;
            Q_minus_one <= 1'b0;
            A           <= '0;
            count       <= CW'(WIDTH);
        end else if (count != '0) begin
            A           <= w_a_nxt;
            Q_temp      <= w_q_nxt;
            Q_minus_one <= w_qm1_nxt;
            count       <= count - 1'b1;
        end
    end

    assign P = {A[WIDTH-1:0], Q_temp};

`ifdef BM_DONE_EN
    logic r_done;

    // done rises on the final step edge and holds until the next load or reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else if (load) begin
            r_done <= 1'b0;
        end else if (count != '0) begin
            r_done <= (count == CW'(1));
        end
    end

    assign done = r_done;
`endif

endmodule

// File: tb/tb_iiitb_r2_4bit_bm.sv
// Bench for iiitb_r2_4bit_bm: directed cases from the datasheet plus randomized
// load/idle/abort/reset traffic, checked every cycle against an arithmetic model.
module tb_iiitb_r2_4bit_bm;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, load;
    logic [W-1:0] M, Q;
    logic [2*W-1:0] P;
`ifdef BM_DONE_EN
    logic         done;
`endif

    iiitb_r2_4bit_bm #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .M     (M),
        .Q     (Q),
`ifdef BM_DONE_EN
        .done  (done),
`endif
        .P     (P)
    );

    always #5 clk = ~clk;

    // Model state: steps remaining, the product owed at the end, the shown product.
    int           m_cnt = 0;
    logic [7:0]   m_pend = '0;
    logic [7:0]   m_p = '0;
    logic         m_done = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_rst = 1'b0;

    // Literal pins requested by the stimulus process, consumed by the compare process.
    int           lit_seq = 0;
    logic [7:0]   lit_val = '0;
    string        lit_name = "";

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi, pr;
        logic [31:0] pv;
        ai = $signed(a);
        bi = $signed(b);
        pr = ai * bi;
        pv = pr;
        return pv[7:0];
    endfunction

    // Behavioural model: the product appears only after WIDTH step edges.
    always @(posedge clk) begin
        if (!reset) begin
            m_valid <= 1'b1;
            m_rst   <= 1'b1;
            m_cnt   <= 0;
            m_p     <= '0;
            m_done  <= 1'b0;
        end else begin
            m_rst <= 1'b0;
            if (load) begin
                m_cnt  <= W;
                m_pend <= smul(M, Q);
                m_done <= 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_p    <= m_pend;
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: runs every cycle once the model is known.
    int lit_seen = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("count", int'(dut.count), m_cnt);
            if (m_cnt == 0) chk("P_idle", int'(P), int'(m_p));
`ifdef BM_DONE_EN
            chk("done", int'(done), int'(m_done));
`endif
            if (m_rst) begin
                chk("rst_M_temp", int'(dut.M_temp), 0);
                chk("rst_Q_temp", int'(dut.Q_temp), 0);
                chk("rst_Qm1", int'(dut.Q_minus_one), 0);
                chk("rst_A", int'(dut.A), 0);
                chk("rst_P", int'(P), 0);
            end
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            chk({lit_name, "_dut"}, int'(P), int'(lit_val));
            chk({lit_name, "_model"}, int'(m_p), int'(lit_val));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [7:0] v);
        lit_name = name;
        lit_val  = v;
        lit_seq++;
    endtask

    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b);
        reset = 1'b1; load = 1'b1; M = a; Q = b;
        tick();
        load = 1'b0; M = $urandom; Q = $urandom;
        repeat (W) tick();
    endtask

    initial begin
        reset = 1'b0; load = 1'b1; M = 4'b0101; Q = 4'b1100;
        tick(); tick();
        pin("reset", 8'h00);
        tick();

        mul(4'b1010, 4'b1011);
        pin("m6xm5", 8'b00011110);
        repeat (3) tick();
        pin("m6xm5_hold", 8'b00011110);
        tick();

        mul(4'b0111, 4'b1000);
        pin("7xm8", 8'b11001000);
        tick();

        mul(4'b1000, 4'b1000);
        pin("m8xm8", 8'b01000000);
        tick();

        // Abort a running multiply two edges in.
        reset = 1'b1; load = 1'b1; M = 4'b0011; Q = 4'b0000;
        tick();
        load = 1'b0;
        tick(); tick();
        mul(4'b0010, 4'b0011);
        pin("restart_2x3", 8'b00000110);
        tick();

        // Reset in the middle of a multiply.
        reset = 1'b1; load = 1'b1; M = 4'b0111; Q = 4'b1000;
        tick();
        load = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        pin("mid_reset", 8'h00);
        reset = 1'b1;
        tick(); tick();
        pin("mid_reset_hold", 8'h00);
        tick();

        mul(4'b0000, 4'b0111);
        pin("zero", 8'h00);
        tick();

        // Random traffic: loads, aborting loads, idle gaps, occasional reset.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            reset = (r < 4) ? 1'b0 : 1'b1;
            load  = (r >= 4 && r < 30) ? 1'b1 : 1'b0;
            M = $urandom;
            Q = $urandom;
            tick();
        end
        reset = 1'b1; load = 1'b0;
        repeat (W + 2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
